// File: rtl/instr_sequencer_if.sv
// Issue-stage bus between the instruction sequencer (master) and its loader/processor (slave).
// Carries the program-load port, start/done pacing and the issued instruction fields.
interface instr_sequencer_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [33:0]   prog_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic          done;
    logic [2:0]    instr;
    logic [4:0]    reg1;
    logic [4:0]    reg2;
    logic [4:0]    reg3;
    logic [15:0]   const_out;
    logic          issue;
    logic [AW:0]   pc;
    logic          busy;
    logic          halted;

    modport master (
        input  prog_we, prog_addr, prog_wdata, prog_len, start, done,
        output instr, reg1, reg2, reg3, const_out, issue, pc, busy, halted
    );

    modport slave (
        output prog_we, prog_addr, prog_wdata, prog_len, start, done,
        input  instr, reg1, reg2, reg3, const_out, issue, pc, busy, halted
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loadable program memory plus PC, issuing one word at a time paced by done.
// Optional SEQ_STEP_EN adds a step input that must be high before each further issue.
module instr_sequencer #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 4
) (
    input logic clk,
    input logic rst_n,
`ifdef SEQ_STEP_EN
    input logic step,
`endif
    instr_sequencer_if.master bus
);
    localparam int CW = (ACK_TIMEOUT < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] TIMEOUT_W = CW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {IDLE, ISSUE, ACK, WAIT, HALT} state_t;

    state_t        state, state_next;
    logic [33:0]   mem [DEPTH];
    logic [33:0]   fields_q;
    logic [AW:0]   pc_q;
    logic [AW:0]   len_eff;
    logic [CW-1:0] ack_cnt;
    logic [AW-1:0] rd_addr;
    logic          prog_open, start_go, at_end, step_ok;
    logic          decide, load, cnt_clr, cnt_inc;

`ifdef SEQ_STEP_EN
    assign step_ok = step;
`else
    assign step_ok = 1'b1;
`endif

    assign len_eff   = (bus.prog_len > DEPTH_W) ? DEPTH_W : bus.prog_len;
    assign at_end    = (pc_q == len_eff);
    assign prog_open = (state == IDLE) || (state == HALT);
    // A write in the same cycle as start wins; start is dropped.
    assign start_go  = prog_open && bus.start && !bus.prog_we;
    assign rd_addr   = start_go ? '0 : pc_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (prog_open && bus.prog_we && ({1'b0, bus.prog_addr} < DEPTH_W)) begin
            mem[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    always_comb begin
        state_next = state;
        decide     = 1'b0;
        load       = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start_go) begin
                    if (len_eff != '0) begin
                        state_next = ISSUE;
                        load       = 1'b1;
                    end else begin
                        state_next = HALT;
                    end
                end
            end
            ISSUE: begin
                state_next = ACK;
                cnt_clr    = 1'b1;
            end
            ACK: begin
                if (!bus.done)                 state_next = WAIT;
                else if (ack_cnt == TIMEOUT_W) decide     = 1'b1;
                else                           cnt_inc    = 1'b1;
            end
            WAIT: decide = bus.done;
            default: state_next = IDLE;
        endcase
        // pc already points past the issued word while in ACK/WAIT.
        if (decide) begin
            if (at_end) begin
                state_next = HALT;
            end else if (step_ok) begin
                state_next = ISSUE;
                load       = 1'b1;
            end else begin
                state_next = WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            ack_cnt  <= '0;
            fields_q <= '0;
        end else begin
            if (start_go)            pc_q <= '0;
            else if (state == ISSUE) pc_q <= pc_q + 1'b1;
            if (cnt_clr)             ack_cnt <= '0;
            else if (cnt_inc)        ack_cnt <= ack_cnt + 1'b1;
            if (load)                fields_q <= mem[rd_addr];
        end
    end

    assign bus.instr     = fields_q[33:31];
    assign bus.reg1      = fields_q[30:26];
    assign bus.reg2      = fields_q[25:21];
    assign bus.reg3      = fields_q[20:16];
    assign bus.const_out = fields_q[15:0];
    assign bus.issue     = (state == ISSUE);
    assign bus.busy      = (state == ISSUE) || (state == ACK) || (state == WAIT);
    assign bus.halted    = (state == HALT);
    assign bus.pc        = pc_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: random programs and done timing against a timeline model.
// Build with SEQ_STEP_EN defined to also exercise the step gate.
module tb_instr_sequencer;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_sequencer_if #(.AW(AW)) bus();
`ifdef SEQ_STEP_EN
    logic step;
`endif

    instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
`ifdef SEQ_STEP_EN
        .step (step),
`endif
        .bus  (bus.master)
    );

    logic [33:0] ref_mem [DEPTH];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fields(input string tag, input logic [33:0] w);
        chk({tag, "_instr"}, 64'(bus.instr),     64'(w[33:31]));
        chk({tag, "_reg1"},  64'(bus.reg1),      64'(w[30:26]));
        chk({tag, "_reg2"},  64'(bus.reg2),      64'(w[25:21]));
        chk({tag, "_reg3"},  64'(bus.reg3),      64'(w[20:16]));
        chk({tag, "_const"}, 64'(bus.const_out), 64'(w[15:0]));
    endtask

    task automatic chk_zero(input string tag);
        chk_fields(tag, 34'd0);
        chk({tag, "_issue"},  64'(bus.issue),  64'd0);
        chk({tag, "_pc"},     64'(bus.pc),     64'd0);
        chk({tag, "_busy"},   64'(bus.busy),   64'd0);
        chk({tag, "_halted"}, 64'(bus.halted), 64'd0);
    endtask

    function automatic logic [33:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[33:0];
    endfunction

    task automatic load_word(input int a, input logic [33:0] w);
        @(negedge clk);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = a[AW-1:0];
        bus.prog_wdata = w;
        @(negedge clk);
        bus.prog_we = 1'b0;
        ref_mem[a]  = w;
    endtask

    // Timeline model: first issue one cycle after start; each later issue/halt one cycle after
    // done is seen high in WAIT, or ISSUE + (TO+1) ACK cycles + 1 when done never falls.
    task automatic run_prog(input int len, input bit hold_done);
        int exp_len, k, exp_evt, drop_at, rise_at, h;
        bit want_issue, want_halt;
        exp_len = (len > DEPTH) ? DEPTH : len;
        k = 0; exp_evt = 1; drop_at = -1; rise_at = -1;
        @(negedge clk);
        bus.prog_len = len[AW:0];
        bus.start    = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            bus.start  = 1'b0;
            want_issue = (cyc == exp_evt) && (k < exp_len);
            want_halt  = (cyc >= exp_evt) && (k >= exp_len);
            chk("issue",  64'(bus.issue),  64'(want_issue));
            chk("halted", 64'(bus.halted), 64'(want_halt));
            chk("busy",   64'(bus.busy),   64'(!want_halt));
            if (want_issue) begin
                chk_fields("field", ref_mem[k]);
                chk("pc_at_issue", 64'(bus.pc), 64'(k));
                k++;
                if (hold_done) begin
                    exp_evt = cyc + TO + 2;
                end else begin
                    h       = $urandom_range(1, 5);
                    drop_at = cyc + 1;
                    rise_at = cyc + 1 + h;
                    exp_evt = rise_at + 1;
                end
                // start while running must be ignored
                if (k < exp_len) bus.start = 1'($urandom_range(0, 1));
            end
            if (cyc == drop_at) bus.done = 1'b0;
            if (cyc == rise_at) bus.done = 1'b1;
            if (want_halt) break;
        end
        chk("pc_at_halt", 64'(bus.pc), 64'(exp_len));
        if (exp_len > 0) chk_fields("hold", ref_mem[exp_len-1]);
        @(negedge clk);
        chk("halt_stays", 64'(bus.halted), 64'd1);
        chk("no_issue_in_halt", 64'(bus.issue), 64'd0);
    endtask

    initial begin
        logic [33:0] w;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.prog_len   = '0;
        bus.start      = 1'b0;
        bus.done       = 1'b1;
`ifdef SEQ_STEP_EN
        step = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        load_word(0, {3'b011, 5'd1, 5'd0, 5'd2, 16'hFFF7});
        for (int i = 1; i < DEPTH; i++) load_word(i, rand_word());

        run_prog(3, 1'b0);
        run_prog(2, 1'b1);
        run_prog(0, 1'b0);

        // Simultaneous write and start: write lands, start is dropped.
        w = rand_word();
        @(negedge clk);
        bus.prog_we = 1'b1; bus.prog_addr = 4'd5; bus.prog_wdata = w; bus.start = 1'b1;
        bus.prog_len = 5'd3;
        @(negedge clk);
        bus.prog_we = 1'b0; bus.start = 1'b0;
        ref_mem[5] = w;
        chk("collide_issue", 64'(bus.issue), 64'd0);
        chk("collide_busy",  64'(bus.busy),  64'd0);

        run_prog(20, 1'b0);
        repeat (3) run_prog($urandom_range(1, DEPTH), 1'($urandom_range(0, 1)));

        // Reset in WAIT of word 1, with an ignored write in WAIT beforehand.
        @(negedge clk);
        bus.prog_len = 5'd3; bus.start = 1'b1; bus.done = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("rst_run_issue0", 64'(bus.issue), 64'd1);
        bus.done = 1'b0;
        repeat (2) @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        chk("rst_run_issue1", 64'(bus.issue), 64'd1);
        chk_fields("rst_run_w1", ref_mem[1]);
        bus.done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_run_wait_busy", 64'(bus.busy), 64'd1);
        bus.prog_we = 1'b1; bus.prog_addr = '0; bus.prog_wdata = ~ref_mem[0];
        @(negedge clk);
        bus.prog_we = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1; bus.done = 1'b1;
        run_prog(3, 1'b0);

`ifdef SEQ_STEP_EN
        step = 1'b0;
        @(negedge clk);
        bus.prog_len = 5'd2; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("step_issue0", 64'(bus.issue), 64'd1);
        bus.done = 1'b0;
        repeat (2) @(negedge clk);
        bus.done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("step_hold_issue", 64'(bus.issue), 64'd0);
            chk("step_hold_busy",  64'(bus.busy),  64'd1);
        end
        step = 1'b1;
        @(negedge clk);
        chk("step_issue1", 64'(bus.issue), 64'd1);
        chk_fields("step_w1", ref_mem[1]);
        step = 1'b0; bus.done = 1'b0;
        repeat (2) @(negedge clk);
        bus.done = 1'b1;
        @(negedge clk);
        chk("step_halt", 64'(bus.halted), 64'd1);
        step = 1'b1;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
